// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter in front of the counter slave.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn   = 2'd1,
    StToAck = 2'd2
  } arb_state_e;

  localparam int unsigned MstIdxW       = 1;
  localparam logic [31:0] DefaultToData = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_watchdog.sv
// Counts consecutive stalled owner cycles; flags expiry on the cycle the count reaches TIMEOUT-1.
module wb_timeout_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CntW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_d, count_q;

  // An ack or an idle strobe restarts the count; expiry leaves OWN so the wrap is harmless.
  always_comb begin
    count_d  = '0;
    expire_o = 1'b0;
    if (active_i && !ack_i) begin
      count_d  = count_q + 1'b1;
      expire_o = (count_q == CntLast);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_counter_arbiter.sv
// Round-robin arbiter sharing the counter's Wishbone slave port between two masters,
// with a watchdog that force-acks stalled cycles.
module wb_counter_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] TO_DATA = DefaultToData
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_flag_o,
  output logic        timeout_id_o,
  input  logic        timeout_clr_i
);

  arb_state_e         state_d, state_q;
  logic [MstIdxW-1:0] owner_d, owner_q;
  logic [MstIdxW-1:0] last_owner_d, last_owner_q;
  logic               flag_d, flag_q;
  logic               id_d, id_q;
  logic               own_cyc, own_stb, expire;

  assign own_cyc = owner_q[0] ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q[0] ? m1_stb_i : m0_stb_i;

  wb_timeout_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .active_i ((state_q == StOwn) && own_cyc && own_stb),
    .ack_i    (s_ack_i),
    .expire_o (expire)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    flag_d       = timeout_clr_i ? 1'b0 : flag_q;
    id_d         = id_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = StOwn;
          owner_d = ~last_owner_q;
        end else if (m0_cyc_i || m1_cyc_i) begin
          state_d = StOwn;
          owner_d = m1_cyc_i;
        end
      end
      StOwn: begin
        if (!own_cyc) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else if (expire) begin
          // A new timeout overrides a same-cycle clear.
          state_d = StToAck;
          flag_d  = 1'b1;
          id_d    = owner_q[0];
        end
      end
      StToAck: begin
        if (own_cyc) begin
          state_d = StOwn;
        end else begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    grant_o  = '0;
    if (state_q != StIdle) begin
      grant_o[owner_q] = 1'b1;
    end
    if (state_q == StOwn) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      s_we_o  = owner_q[0] ? m1_we_i  : m0_we_i;
      s_sel_o = owner_q[0] ? m1_sel_i : m0_sel_i;
      s_adr_o = owner_q[0] ? m1_adr_i : m0_adr_i;
      s_dat_o = owner_q[0] ? m1_dat_i : m0_dat_i;
    end
    if (state_q == StOwn || state_q == StToAck) begin
      if (owner_q[0]) begin
        m1_ack_o = (state_q == StToAck) ? 1'b1 : s_ack_i;
        m1_dat_o = (state_q == StToAck) ? TO_DATA : s_dat_i;
      end else begin
        m0_ack_o = (state_q == StToAck) ? 1'b1 : s_ack_i;
        m0_dat_o = (state_q == StToAck) ? TO_DATA : s_dat_i;
      end
    end
  end

  assign timeout_flag_o = flag_q;
  assign timeout_id_o   = id_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= 1'b1;
      flag_q       <= 1'b0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      flag_q       <= flag_d;
      id_q         <= id_d;
    end
  end

endmodule

// File: tb/tb_wb_counter_arbiter.sv
// Directed bench for wb_counter_arbiter: the bench plays the counter slave and both masters.
module tb_wb_counter_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m0_ack;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic        m1_cyc, m1_stb, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        to_flag, to_id, to_clr;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  wb_counter_arbiter #(
    .TIMEOUT (16),
    .TO_DATA (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .m0_cyc_i       (m0_cyc),
    .m0_stb_i       (m0_stb),
    .m0_we_i        (m0_we),
    .m0_sel_i       (m0_sel),
    .m0_adr_i       (m0_adr),
    .m0_dat_i       (m0_wdat),
    .m0_ack_o       (m0_ack),
    .m0_dat_o       (m0_rdat),
    .m1_cyc_i       (m1_cyc),
    .m1_stb_i       (m1_stb),
    .m1_we_i        (m1_we),
    .m1_sel_i       (m1_sel),
    .m1_adr_i       (m1_adr),
    .m1_dat_i       (m1_wdat),
    .m1_ack_o       (m1_ack),
    .m1_dat_o       (m1_rdat),
    .s_cyc_o        (s_cyc),
    .s_stb_o        (s_stb),
    .s_we_o         (s_we),
    .s_sel_o        (s_sel),
    .s_adr_o        (s_adr),
    .s_dat_o        (s_wdat),
    .s_ack_i        (s_ack),
    .s_dat_i        (s_rdat),
    .grant_o        (grant),
    .timeout_flag_o (to_flag),
    .timeout_id_o   (to_id),
    .timeout_clr_i  (to_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, to_clr} = '0;
    m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
    m1_sel = 4'hF; m1_adr = 32'h3000_0004; m1_wdat = 32'h0000_00A5;
    s_rdat = 32'h1234_5678;
    #3;
    check("rst_grant", grant, 0);
    check("rst_scyc", s_cyc, 0);
    check("rst_flag", to_flag, 0);
    check("rst_m0dat", m0_rdat, 0);
    tick();
    rst = 1'b0;

    // Single m0 write: one cycle arbitration latency, then a transparent path.
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'h1;
    m0_adr = 32'h3000_0000; m0_wdat = 32'h0000_005A;
    #1;
    check("w_latency_scyc", s_cyc, 0);
    tick();
    check("w_grant", grant, 2'b01);
    check("w_scyc", s_cyc, 1);
    check("w_sstb", s_stb, 1);
    check("w_swe", s_we, 1);
    check("w_ssel", s_sel, 4'h1);
    check("w_sadr", s_adr, 32'h3000_0000);
    check("w_sdat", s_wdat, 32'h0000_005A);
    check("w_m0ack_pre", m0_ack, 0);
    s_ack = 1;
    #1;
    check("w_m0ack", m0_ack, 1);
    check("w_m1ack", m1_ack, 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    check("w_drop_scyc", s_cyc, 0);
    tick();
    check("w_idle_grant", grant, 0);

    // Simultaneous requests straight after reset: m0 first, then alternation.
    rst = 1; #1; rst = 0; #1;
    m0_cyc = 1; m0_stb = 1; m0_we = 0;
    m1_cyc = 1; m1_stb = 1; m1_we = 0;
    tick();
    check("c_first_m0", grant, 2'b01);
    s_ack = 1;
    #1;
    check("c_m0ack", m0_ack, 1);
    check("c_m0dat", m0_rdat, 32'h1234_5678);
    check("c_m1ack_stall", m1_ack, 0);
    check("c_m1dat_stall", m1_rdat, 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    check("c_gap_idle", grant, 0);
    m0_cyc = 1; m0_stb = 1;
    tick();
    check("c_fair_m1", grant, 2'b10);
    check("c_m1adr", s_adr, 32'h3000_0004);
    m1_cyc = 0; m1_stb = 0;
    tick();
    check("c_gap2_idle", grant, 0);
    m1_cyc = 1; m1_stb = 1;
    tick();
    check("c_fair_m0", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    tick();
    check("c_end_idle", grant, 0);

    // m1 read with the slave never acking: 16 stalled OWN cycles, then the forced ack.
    m1_cyc = 1; m1_stb = 1; m1_we = 0;
    tick();
    for (int i = 1; i < 16; i++) begin
      check("t_stall_m1ack", m1_ack, 0);
      tick();
    end
    check("t_c16_m1ack", m1_ack, 0);
    check("t_c16_sstb", s_stb, 1);
    check("t_c16_flag", to_flag, 0);
    tick();
    check("t_toack_m1ack", m1_ack, 1);
    check("t_toack_m1dat", m1_rdat, 32'hDEAD_BEEF);
    check("t_toack_sstb", s_stb, 0);
    check("t_toack_scyc", s_cyc, 0);
    check("t_toack_flag", to_flag, 1);
    check("t_toack_id", to_id, 1);
    check("t_toack_grant", grant, 2'b10);
    m1_cyc = 0; m1_stb = 0;
    tick();
    check("t_sticky_flag", to_flag, 1);
    check("t_idle_grant", grant, 0);
    to_clr = 1;
    tick();
    to_clr = 0;
    check("t_clr_flag", to_flag, 0);

    // m0 timeout with a same-cycle clear: the set wins, then OWN resumes.
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int i = 1; i < 16; i++) tick();
    to_clr = 1;
    tick();
    to_clr = 0;
    check("s_setwins_flag", to_flag, 1);
    check("s_id", to_id, 0);
    check("s_m0ack", m0_ack, 1);
    check("s_m0dat", m0_rdat, 32'hDEAD_BEEF);
    tick();
    check("s_reown_grant", grant, 2'b01);
    check("s_reown_sstb", s_stb, 1);

    // Ack on the cycle the count hits TIMEOUT-1 is a normal ack.
    for (int i = 1; i < 16; i++) tick();
    s_ack = 1;
    #1;
    check("a_ack_m0", m0_ack, 1);
    check("a_ack_m0dat", m0_rdat, 32'h1234_5678);
    tick();
    s_ack = 0;
    #1;
    check("a_no_toack_scyc", s_cyc, 1);
    check("a_no_toack_m0ack", m0_ack, 0);

    // Abandon mid-transfer; a late ack in IDLE is ignored.
    m0_cyc = 0; m0_stb = 0;
    #1;
    check("b_abandon_scyc", s_cyc, 0);
    tick();
    s_ack = 1;
    #1;
    check("b_late_ack", m0_ack, 0);
    s_ack = 0;

    // Asynchronous reset mid-transfer, then re-grant one edge after release.
    m0_cyc = 1; m0_stb = 1;
    tick();
    check("r_pre_scyc", s_cyc, 1);
    s_ack = 1;
    rst = 1;
    #1;
    check("r_grant", grant, 0);
    check("r_scyc", s_cyc, 0);
    check("r_m0ack", m0_ack, 0);
    check("r_flag", to_flag, 0);
    check("r_sadr", s_adr, 0);
    s_ack = 0;
    #1;
    rst = 0;
    #1;
    check("r_rel_idle", grant, 0);
    tick();
    check("r_regrant", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
